// File: rtl/pwm_gen.sv
// pwm_gen: complementary high/low gate driver with fixed on-time, controller
// supplied off-time and optional dead-time between phases.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   enable        - level run request; dropping it aborts the current period
//   off_div       - requested off-time in cycles (latched when pwm_rdy)
//   pwm_rdy       - controller idle, off_div stable
//   pwm_en        - one-cycle pulse on the first ON cycle (starts controller)
//   gate_hi/lo    - high-side / low-side drive, never both high
//   period_done   - one-cycle pulse on the last cycle of a completed period
module pwm_gen #(
  parameter int unsigned ON_TIME   = 40,
  parameter int unsigned CNT_WIDTH = 18,
  parameter int unsigned DEAD_TIME = 4,
  parameter int unsigned MIN_OFF   = 2,
  parameter int unsigned START_OFF = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] off_div,
  input  logic                 pwm_rdy,
  output logic                 pwm_en,
  output logic                 gate_hi,
  output logic                 gate_lo,
  output logic                 period_done
);

  localparam logic [CNT_WIDTH-1:0] ON_LOAD   = CNT_WIDTH'(ON_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] DEAD_LOAD = CNT_WIDTH'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] MIN_VAL   = CNT_WIDTH'(MIN_OFF);
  localparam logic [CNT_WIDTH-1:0] START_VAL = CNT_WIDTH'(START_OFF);
  localparam bit                   NO_DEAD   = (DEAD_TIME == 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ON     = 3'd1,
    S_DEAD_A = 3'd2,
    S_OFF    = 3'd3,
    S_DEAD_B = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
  logic                 pwm_en_q, pwm_en_d;
  logic                 gate_hi_q, gate_hi_d;
  logic                 gate_lo_q, gate_lo_d;
  logic                 done_q, done_d;
  logic                 phase_last;
  logic                 end_period;

  // State, counter, shadow off-time and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shadow_q  <= START_VAL;
      pwm_en_q  <= 1'b0;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pwm_en_q  <= pwm_en_d;
      gate_hi_q <= gate_hi_d;
      gate_lo_q <= gate_lo_d;
      done_q    <= done_d;
    end
  end

  // Next-state, phase counter, off-time latch and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    end_period = 1'b0;
    phase_last = (cnt_q == '0);

    if (!phase_last) cnt_d = cnt_q - CNT_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ON;
          cnt_d   = ON_LOAD;
        end
      end
      S_ON: begin
        if (phase_last) begin
          if (pwm_rdy) shadow_d = (off_div < MIN_VAL) ? MIN_VAL : off_div;
          if (NO_DEAD) begin
            state_d = S_OFF;
            // Freshly latched value applies to this period's OFF phase
            cnt_d   = shadow_d - CNT_WIDTH'(1);
          end else begin
            state_d = S_DEAD_A;
            cnt_d   = DEAD_LOAD;
          end
        end
      end
      S_DEAD_A: begin
        if (phase_last) begin
          state_d = S_OFF;
          cnt_d   = shadow_q - CNT_WIDTH'(1);
        end
      end
      S_OFF: begin
        if (phase_last) begin
          if (NO_DEAD) begin
            end_period = 1'b1;
          end else begin
            state_d = S_DEAD_B;
            cnt_d   = DEAD_LOAD;
          end
        end
      end
      S_DEAD_B: begin
        if (phase_last) end_period = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (end_period) begin
      if (enable) begin
        state_d = S_ON;
        cnt_d   = ON_LOAD;
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end

    // Abort: drop to IDLE, keep the previously latched off-time
    if ((state_q != S_IDLE) && !enable) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      shadow_d = shadow_q;
    end

    // Outputs decoded from the next state so they register alongside it
    gate_hi_d = (state_d == S_ON);
    gate_lo_d = (state_d == S_OFF);
    pwm_en_d  = (state_d == S_ON) && (state_q != S_ON);
    done_d    = ((state_d == S_DEAD_B) || (NO_DEAD && (state_d == S_OFF)))
                && (cnt_d == '0);
  end

  assign pwm_en      = pwm_en_q;
  assign gate_hi     = gate_hi_q;
  assign gate_lo     = gate_lo_q;
  assign period_done = done_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: directed periods on a dead-time instance,
// random off-times on a zero-dead-time instance.
module tb_pwm_gen;

  localparam int unsigned CW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, pwm_rdy;
  logic [CW-1:0] off_div;
  logic          pwm_en, gate_hi, gate_lo, period_done;

  logic          enable1, pwm_rdy1;
  logic [CW-1:0] off_div1;
  logic          pwm_en1, gate_hi1, gate_lo1, period_done1;

  always #5 clk = ~clk;

  pwm_gen #(.ON_TIME(8), .CNT_WIDTH(CW), .DEAD_TIME(2), .MIN_OFF(2), .START_OFF(100)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .off_div(off_div), .pwm_rdy(pwm_rdy),
    .pwm_en(pwm_en), .gate_hi(gate_hi), .gate_lo(gate_lo), .period_done(period_done)
  );

  pwm_gen #(.ON_TIME(8), .CNT_WIDTH(CW), .DEAD_TIME(0), .MIN_OFF(2), .START_OFF(100)) u_dut_nd (
    .clk(clk), .rst(rst), .enable(enable1), .off_div(off_div1), .pwm_rdy(pwm_rdy1),
    .pwm_en(pwm_en1), .gate_hi(gate_hi1), .gate_lo(gate_lo1), .period_done(period_done1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected shape of one completed period
  typedef struct {
    int hi;
    int da;
    int lo;
    int db;
    int len;
  } per_t;

  per_t exp_q[$];
  int   lo_q1[$];
  int   done_cnt = 0;

  function automatic per_t mk(input int lo);
    per_t p;
    p.hi = 8; p.da = 2; p.lo = lo; p.db = 2; p.len = 12 + lo;
    return p;
  endfunction

  // Monitor for the dead-time instance: measure each period, compare on period_done
  int  hi_n, da_n, lo_n, db_n, cyc_n;
  bit  seen_en;
  logic prev_hi;
  initial begin
    hi_n = 0; da_n = 0; lo_n = 0; db_n = 0; cyc_n = 0; seen_en = 0; prev_hi = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("excl", 64'(gate_hi & gate_lo), 0);
      if (pwm_en) begin
        chk("pwm_en_with_hi", 64'(gate_hi), 1);
        chk("pwm_en_first_on", 64'(prev_hi), 0);
        hi_n = 0; da_n = 0; lo_n = 0; db_n = 0; cyc_n = 0; seen_en = 1;
      end
      cyc_n++;
      if (gate_hi) hi_n++;
      else if (gate_lo) lo_n++;
      else if (lo_n == 0) da_n++;
      else db_n++;
      if (period_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("period_done_unexpected_qsize", 64'(exp_q.size()), 1);
        end else begin
          per_t e;
          e = exp_q.pop_front();
          chk("on_len", hi_n, e.hi);
          chk("dead_a_len", da_n, e.da);
          chk("off_len", lo_n, e.lo);
          chk("dead_b_len", db_n, e.db);
          chk("period_len", cyc_n, e.len);
          chk("pwm_en_seen", 64'(seen_en), 1);
        end
        seen_en = 0;
      end
    end
    prev_hi = gate_hi;
  end

  // Monitor for the zero-dead-time instance: contiguity and latched off-time
  int   hi1_run, lo1_run;
  logic prev_hi1, prev_lo1;
  initial begin
    hi1_run = 0; lo1_run = 0; prev_hi1 = 0; prev_lo1 = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      a_excl1: assert (!(gate_hi1 && gate_lo1))
        else $error("FAIL excl1: gate_hi1 and gate_lo1 both high at %0t", $time);
      chk("excl1", 64'(gate_hi1 & gate_lo1), 0);
      if (gate_hi1 && !prev_hi1) hi1_run = 0;
      if (gate_hi1) begin
        hi1_run++;
        if (hi1_run == 8) lo_q1.push_back((off_div1 < 2) ? 2 : int'(off_div1));
      end
      if (prev_hi1 && !gate_hi1 && enable1) chk("contig_on_off", 64'(gate_lo1), 1);
      if (gate_lo1 && !prev_lo1) lo1_run = 0;
      if (gate_lo1) lo1_run++;
      if (prev_lo1 && !gate_lo1 && enable1) begin
        chk("contig_off_on", 64'(gate_hi1), 1);
        if (lo_q1.size() == 0) chk("off1_unexpected_qsize", 64'(lo_q1.size()), 1);
        else chk("off1_len", lo1_run, lo_q1.pop_front());
      end
    end
    prev_hi1 = gate_hi1;
    prev_lo1 = gate_lo1;
  end

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 600) begin
      @(negedge clk); #1; n++;
    end
    chk("wait_done", done_cnt, target);
  endtask

  initial begin
    rst = 1; enable = 0; pwm_rdy = 1; off_div = CW'(10);
    enable1 = 0; pwm_rdy1 = 1; off_div1 = CW'(10);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gate_hi", 64'(gate_hi), 0);
    chk("rst_gate_lo", 64'(gate_lo), 0);
    chk("rst_pwm_en", 64'(pwm_en), 0);
    chk("rst_period_done", 64'(period_done), 0);
    rst = 0;
    @(negedge clk); #1;
    chk("idle_gate_hi", 64'(gate_hi), 0);

    // Nominal periods
    exp_q.push_back(mk(10)); exp_q.push_back(mk(10)); exp_q.push_back(mk(10));
    enable = 1;
    @(negedge clk); #1;
    chk("start_gate_hi", 64'(gate_hi), 1);
    chk("start_pwm_en", 64'(pwm_en), 1);
    wait_done(3);

    // Update gating: not ready -> old value, then ready -> new value
    pwm_rdy = 0; off_div = CW'(30); exp_q.push_back(mk(10));
    wait_done(4);
    pwm_rdy = 1; exp_q.push_back(mk(30));
    wait_done(5);

    // Clamp to MIN_OFF
    off_div = CW'(0); exp_q.push_back(mk(2));
    wait_done(6);
    off_div = CW'(1); exp_q.push_back(mk(2));
    wait_done(7);

    // Abort on the 5th OFF cycle
    off_div = CW'(10);
    begin
      int k = 0;
      int n = 0;
      while (k < 5 && n < 200) begin
        @(negedge clk); #1; n++;
        if (gate_lo) k++;
      end
      chk("abort_reach_off5", k, 5);
    end
    enable = 0;
    @(negedge clk); #1;
    chk("abort_gate_lo", 64'(gate_lo), 0);
    chk("abort_gate_hi", 64'(gate_hi), 0);
    repeat (6) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt, 7);
    chk("abort_idle_lo", 64'(gate_lo), 0);

    // Restart
    exp_q.push_back(mk(10));
    enable = 1;
    @(negedge clk); #1;
    chk("restart_gate_hi", 64'(gate_hi), 1);
    chk("restart_pwm_en", 64'(pwm_en), 1);
    wait_done(8);

    // Asynchronous reset mid-ON
    begin
      int k = 0;
      int n = 0;
      while (k < 3 && n < 50) begin
        @(negedge clk); #1; n++;
        if (gate_hi) k++;
      end
      chk("reset_reach_on3", k, 3);
    end
    #1 rst = 1;
    #1;
    chk("async_rst_gate_hi", 64'(gate_hi), 0);
    chk("async_rst_pwm_en", 64'(pwm_en), 0);
    pwm_rdy = 0; off_div = CW'(50);
    exp_q.push_back(mk(100));
    repeat (2) @(negedge clk);
    #1 rst = 0;
    @(negedge clk); #1;
    chk("post_rst_gate_hi", 64'(gate_hi), 1);
    chk("post_rst_pwm_en", 64'(pwm_en), 1);
    wait_done(9);
    enable = 0; pwm_rdy = 1;
    repeat (4) @(negedge clk);
    #1;
    chk("final_idle_done_cnt", done_cnt, 9);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);

    // Zero dead-time instance with random off-times
    @(posedge clk); #1;
    enable1 = 1;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      off_div1 = CW'($urandom_range(0, 40));
    end
    chk("nd_periods_checked_nonzero", 64'(lo1_run > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
